mu0_demux16_reg: RTL and testbench

- Registered 1-to-2, 16-bit demultiplexer; the inverse of the MU0 16-bit 2:1 select path.
- Steers one incoming data word to channel A or channel B, chosen by the select S.
- Each channel has a one-entry holding register with valid/ready handshakes on both sides.
- Used in the MU0 datapath to route the memory/ALU result bus to one of two consumers, e.g. ACC load path and IR/PC load path.

---
 rtl/mu0_pkg.sv | 16 +
 rtl/mu0_hold_reg16.sv | 54 +++++
 rtl/mu0_demux16_reg.sv | 63 ++++++
 tb/tb_mu0_demux16_reg.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// Shared constants and types for the MU0 registered 1-to-2 demultiplexer.
package mu0_pkg;

   localparam int MU0_WIDTH = 16;

   // Channel select encodings on S
   localparam logic MU0_SEL_A = 1'b0;
   localparam logic MU0_SEL_B = 1'b1;

   // Occupancy of a one-entry channel holding register
   typedef enum logic {
      CH_EMPTY = 1'b0,
      CH_FULL  = 1'b1
   } ch_state_t;

endpackage

// File: rtl/mu0_hold_reg16.sv
// One-entry holding register with a valid/ready handshake on its output side.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   CH_EMPTY | no word held, Valid = 0, Q keeps its last word
//   CH_FULL  | Q holds an unconsumed word, Valid = 1
//
// Load must only be raised while CanLoad is high. The caller enforces this.
module mu0_hold_reg16
   import mu0_pkg::*;
#(
   parameter int WIDTH = MU0_WIDTH
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic             Load,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] Q,
   output logic             Valid,
   input  logic             Ready,
   output logic             CanLoad
);

   ch_state_t state;

   // Channel occupancy and held word; a drain leaves Q untouched.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state <= CH_EMPTY;
         Q     <= '0;
      end else begin
         case (state)
            CH_EMPTY: begin
               if (Load) begin
                  state <= CH_FULL;
                  Q     <= Din;
               end
            end
            CH_FULL: begin
               if (Load) begin
                  Q <= Din;
               end else if (Ready) begin
                  state <= CH_EMPTY;
               end
            end
            default: state <= CH_EMPTY;
         endcase
      end
   end

   assign Valid   = (state == CH_FULL);
   assign CanLoad = (state == CH_EMPTY) || Ready;

endmodule

// File: rtl/mu0_demux16_reg.sv
// Registered 1-to-2 demultiplexer: steers D into channel A or B by S.
// InReady depends only on the selected channel, so a stalled channel never
// blocks traffic to the other one. No combinational path exists from D to Q.
module mu0_demux16_reg
   import mu0_pkg::*;
#(
   parameter int WIDTH = MU0_WIDTH
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic [WIDTH-1:0] D,
   input  logic             S,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] QA,
   output logic             AValid,
   input  logic             AReady,
   output logic [WIDTH-1:0] QB,
   output logic             BValid,
   input  logic             BReady
);

   logic a_can_load;
   logic b_can_load;
   logic in_fire;
   logic load_a;
   logic load_b;

   // Ready mux plus gating by nReset so nothing is accepted while in reset.
   always_comb begin
      InReady = 1'b0;
      if (nReset) begin
         InReady = (S == MU0_SEL_B) ? b_can_load : a_can_load;
      end
   end

   assign in_fire = InValid && InReady;
   assign load_a  = in_fire && (S == MU0_SEL_A);
   assign load_b  = in_fire && (S == MU0_SEL_B);

   mu0_hold_reg16 #(.WIDTH(WIDTH)) u_ch_a (
      .Clk     (Clk),
      .nReset  (nReset),
      .Load    (load_a),
      .Din     (D),
      .Q       (QA),
      .Valid   (AValid),
      .Ready   (AReady),
      .CanLoad (a_can_load)
   );

   mu0_hold_reg16 #(.WIDTH(WIDTH)) u_ch_b (
      .Clk     (Clk),
      .nReset  (nReset),
      .Load    (load_b),
      .Din     (D),
      .Q       (QB),
      .Valid   (BValid),
      .Ready   (BReady),
      .CanLoad (b_can_load)
   );

endmodule

// File: tb/tb_mu0_demux16_reg.sv
// Bench for mu0_demux16_reg: directed stimulus, with a queue-based channel model
// checked by a separate monitor on the falling clock edge.
module tb_mu0_demux16_reg;

   logic        Clk;
   logic        nReset;
   logic [15:0] D;
   logic        S;
   logic        InValid;
   logic        InReady;
   logic [15:0] QA;
   logic        AValid;
   logic        AReady;
   logic [15:0] QB;
   logic        BValid;
   logic        BReady;

   int errors = 0;
   int checks = 0;

   // Expected content of each channel's holding register.
   logic [15:0] qa[$];
   logic [15:0] qb[$];
   // Value Q must retain once its channel drains.
   logic [15:0] last_a;
   logic [15:0] last_b;

   mu0_demux16_reg dut (
      .Clk     (Clk),
      .nReset  (nReset),
      .D       (D),
      .S       (S),
      .InValid (InValid),
      .InReady (InReady),
      .QA      (QA),
      .AValid  (AValid),
      .AReady  (AReady),
      .QB      (QB),
      .BValid  (BValid),
      .BReady  (BReady)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares DUT against the queue model, then advances the model.
   always @(negedge Clk) begin
      logic exp_ir;
      if (!nReset) begin
         check("rst_avalid", {15'd0, AValid}, 16'd0);
         check("rst_bvalid", {15'd0, BValid}, 16'd0);
         check("rst_qa", QA, 16'd0);
         check("rst_qb", QB, 16'd0);
         check("rst_inready", {15'd0, InReady}, 16'd0);
         qa.delete();
         qb.delete();
         last_a = 16'd0;
         last_b = 16'd0;
      end else begin
         exp_ir = S ? (qb.size() == 0 || BReady) : (qa.size() == 0 || AReady);
         check("inready", {15'd0, InReady}, {15'd0, exp_ir});
         check("avalid", {15'd0, AValid}, {15'd0, qa.size() != 0});
         check("bvalid", {15'd0, BValid}, {15'd0, qb.size() != 0});
         check("qa", QA, (qa.size() != 0) ? qa[0] : last_a);
         check("qb", QB, (qb.size() != 0) ? qb[0] : last_b);
         if (qa.size() != 0 && AReady) last_a = qa.pop_front();
         if (qb.size() != 0 && BReady) last_b = qb.pop_front();
         if (InValid && exp_ir) begin
            if (S) qb.push_back(D);
            else   qa.push_back(D);
         end
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      nReset  = 1'b0;
      D       = 16'hFFFF;
      S       = 1'b0;
      InValid = 1'b1;
      AReady  = 1'b0;
      BReady  = 1'b0;
      last_a  = 16'd0;
      last_b  = 16'd0;
      repeat (3) step();

      // Release reset with no pending input
      nReset  = 1'b1;
      InValid = 1'b0;
      step();
      step();

      // Route to A, then stall a second word behind it
      D = 16'h1234; S = 1'b0; InValid = 1'b1;
      step();
      D = 16'h5678;
      step();
      step();
      AReady = 1'b1;
      step();
      InValid = 1'b0; AReady = 1'b0;
      step();

      // A stalled; B still accepts
      D = 16'hBEEF; S = 1'b1; InValid = 1'b1;
      step();
      InValid = 1'b0;
      step();
      step();
      BReady = 1'b1;
      step();
      BReady = 1'b0;
      step();

      // Back-to-back stream into A with AReady held
      AReady = 1'b1; S = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         D = 16'(i); InValid = 1'b1;
         step();
      end
      InValid = 1'b0;
      step();
      step();
      AReady = 1'b0;
      step();

      // Fill both channels, then reset asynchronously between edges
      D = 16'hAAAA; S = 1'b0; InValid = 1'b1;
      step();
      D = 16'h5555; S = 1'b1;
      step();
      InValid = 1'b0;
      step();
      #1;
      nReset = 1'b0;
      qa.delete();
      qb.delete();
      last_a = 16'd0;
      last_b = 16'd0;
      #1;
      check("async_avalid", {15'd0, AValid}, 16'd0);
      check("async_bvalid", {15'd0, BValid}, 16'd0);
      check("async_qa", QA, 16'd0);
      check("async_qb", QB, 16'd0);
      check("async_inready", {15'd0, InReady}, 16'd0);
      #1;
      nReset = 1'b1;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

endmodule
